// File: rtl/rs232_ctrl_if.sv
// CPU data-bus port of rs232_ctrl: single request/ready handshake.
interface rs232_ctrl_if;
  logic        bus_sel;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (output bus_sel, bus_we, bus_addr, bus_wdata,
                  input  bus_rdata, bus_ready);
  modport slave  (input  bus_sel, bus_we, bus_addr, bus_wdata,
                  output bus_rdata, bus_ready);
endinterface

// File: rtl/rs232_ctrl.sv
// Memory-mapped RS-232 port controller: TX/RX FIFOs, paced wr_en drain,
// periodic rd_en polling, status/ctrl registers and a level interrupt.
//
// state  | meaning
// T_IDLE | nothing to send or TX disabled
// T_SEND | rs_wr_en high for one cycle, head already popped
// T_GAP  | TX_GAP idle cycles before the next send may start
// R_IDLE | poll counter running while RX enabled and RX FIFO not full
// R_REQ  | rs_rd_en high for one cycle
// R_WAIT | sample rs_rd_valid, push byte if valid
module rs232_ctrl #(
  parameter int TX_DEPTH      = 8,
  parameter int RX_DEPTH      = 8,
  parameter int TX_GAP        = 4,
  parameter int POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  rs232_ctrl_if.slave bus,
  output logic        irq,
  output logic        rs_wr_en,
  output logic [7:0]  rs_wr_data,
  output logic        rs_rd_en,
  input  logic [7:0]  rs_rd_data,
  input  logic        rs_rd_valid
);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int RA = $clog2(RX_DEPTH);
  localparam int GW = $clog2(TX_GAP + 1);
  localparam int PW = $clog2(POLL_INTERVAL);

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_st_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rx_st_t;

  logic [7:0]  r_tx_mem [TX_DEPTH];
  logic [7:0]  r_rx_mem [RX_DEPTH];
  logic [TA:0] r_tx_wp, r_tx_rp;
  logic [RA:0] r_rx_wp, r_rx_rp;
  logic [3:0]  r_ctrl;
  logic        r_tx_ovf;
  logic        r_ready;
  logic [31:0] r_rdata;
  tx_st_t      r_tx_st;
  rx_st_t      r_rx_st;
  logic [GW-1:0] r_gap_cnt;
  logic [PW-1:0] r_poll_cnt;

  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_accept, w_tx_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [1:0]  w_reg;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TA] != r_tx_rp[TA]) && (r_tx_wp[TA-1:0] == r_tx_rp[TA-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[RA] != r_rx_rp[RA]) && (r_rx_wp[RA-1:0] == r_rx_rp[RA-1:0]);

  assign w_reg     = bus.bus_addr[3:2];
  assign w_accept  = bus.bus_sel & ~r_ready;
  assign w_tx_wr   = w_accept & bus.bus_we & (w_reg == 2'd0);
  assign w_tx_push = w_tx_wr & ~w_tx_full;
  assign w_rx_pop  = w_accept & ~bus.bus_we & (w_reg == 2'd0) & ~w_rx_empty;
  // A pop happens on the edge that enters T_SEND, so the head is registered onto rs_wr_data.
  assign w_tx_pop  = r_ctrl[0] & ~w_tx_empty &
                     ((r_tx_st == T_IDLE) | ((r_tx_st == T_GAP) & (r_gap_cnt == '0)));
  assign w_rx_push = (r_rx_st == R_WAIT) & rs_rd_valid;

  assign irq           = (r_ctrl[3] & ~w_rx_empty) | (r_ctrl[2] & w_tx_empty);
  assign bus.bus_ready = r_ready;
  assign bus.bus_rdata = r_rdata;
  assign w_unused      = &{1'b0, bus.bus_addr[1:0], bus.bus_wdata[31:8]};

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      2'd0: w_rdata = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp[RA-1:0]]};
      2'd1: w_rdata = {27'd0, r_tx_ovf, w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};
      2'd2: w_rdata = {28'd0, r_ctrl};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TA-1:0]] <= bus.bus_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[RA-1:0]] <= rs_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + (TA+1)'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + (TA+1)'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + (RA+1)'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + (RA+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_ctrl   <= 4'h3;
      r_tx_ovf <= 1'b0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept & ~bus.bus_we) ? w_rdata : 32'd0;
      if (w_tx_wr & w_tx_full) r_tx_ovf <= 1'b1;
      if (w_accept & bus.bus_we & (w_reg == 2'd1) & bus.bus_wdata[4]) r_tx_ovf <= 1'b0;
      if (w_accept & bus.bus_we & (w_reg == 2'd2)) r_ctrl <= bus.bus_wdata[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st    <= T_IDLE;
      r_gap_cnt  <= '0;
      rs_wr_en   <= 1'b0;
      rs_wr_data <= '0;
    end else begin
      case (r_tx_st)
        T_IDLE: begin
          if (w_tx_pop) begin
            r_tx_st    <= T_SEND;
            rs_wr_en   <= 1'b1;
            rs_wr_data <= r_tx_mem[r_tx_rp[TA-1:0]];
          end
        end
        T_SEND: begin
          rs_wr_en  <= 1'b0;
          r_tx_st   <= T_GAP;
          r_gap_cnt <= GW'(TX_GAP - 1);
        end
        T_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end else if (w_tx_pop) begin
            r_tx_st    <= T_SEND;
            rs_wr_en   <= 1'b1;
            rs_wr_data <= r_tx_mem[r_tx_rp[TA-1:0]];
          end else begin
            r_tx_st <= T_IDLE;
          end
        end
        default: begin
          r_tx_st  <= T_IDLE;
          rs_wr_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st    <= R_IDLE;
      r_poll_cnt <= '0;
      rs_rd_en   <= 1'b0;
    end else begin
      case (r_rx_st)
        R_IDLE: begin
          if (r_ctrl[1] & ~w_rx_full) begin
            if (r_poll_cnt == PW'(POLL_INTERVAL - 1)) begin
              r_poll_cnt <= '0;
              r_rx_st    <= R_REQ;
              rs_rd_en   <= 1'b1;
            end else begin
              r_poll_cnt <= r_poll_cnt + PW'(1);
            end
          end else begin
            r_poll_cnt <= '0;
          end
        end
        R_REQ: begin
          rs_rd_en <= 1'b0;
          r_rx_st  <= R_WAIT;
        end
        R_WAIT: begin
          r_rx_st    <= R_IDLE;
          r_poll_cnt <= '0;
        end
        default: begin
          r_rx_st  <= R_IDLE;
          rs_rd_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs232_ctrl.sv
// Directed-sequence bench for rs232_ctrl with random data, a queue-based
// port model and queue-based FIFO/status expectations.
module tb_rs232_ctrl;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int GAP = 4;
  localparam int PI  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       irq, rs_wr_en, rs_rd_en;
  logic [7:0] rs_wr_data;
  logic [7:0] rs_rd_data = 8'h00;
  logic       rs_rd_valid = 1'b0;

  rs232_ctrl_if bif();

  rs232_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GAP(GAP), .POLL_INTERVAL(PI)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .irq(irq),
    .rs_wr_en(rs_wr_en), .rs_wr_data(rs_wr_data), .rs_rd_en(rs_rd_en),
    .rs_rd_data(rs_rd_data), .rs_rd_valid(rs_rd_valid));

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  int         last_acc = 0;
  logic [7:0] src_q[$];
  logic [7:0] tx_seen[$];
  int         tx_cyc[$];
  int         rd_cyc[$];
  logic       pend = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rs_wr_en) begin
      tx_seen.push_back(rs_wr_data);
      tx_cyc.push_back(cyc);
    end
    if (rs_rd_en) rd_cyc.push_back(cyc);
    pend = rs_rd_en;
  end

  // Port model: a poll seen in cycle N is answered with valid during N+1.
  always @(posedge clk) begin
    #1;
    if (pend && src_q.size() > 0) begin
      rs_rd_valid = 1'b1;
      rs_rd_data  = src_q.pop_front();
    end else begin
      rs_rd_valid = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [3:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    @(negedge clk);
    bif.bus_sel = 1'b1; bif.bus_we = we; bif.bus_addr = a; bif.bus_wdata = wd;
    @(negedge clk);
    last_acc = cyc;
    check("bus_ready", {31'd0, bif.bus_ready}, 32'd1);
    rd = bif.bus_rdata;
    bif.bus_sel = 1'b0; bif.bus_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_xfer(1'b0, a, 32'd0, d);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_seen.size() < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] status_of(input int rxn, input int txn, input logic ovf);
    return {27'd0, ovf, txn == TXD, txn == 0, rxn == RXD, rxn != 0};
  endfunction

  logic [31:0] v;
  logic [7:0]  b [3];
  logic [7:0]  tx_model[$];
  logic [7:0]  rx_exp[$];
  logic        ovf;
  int          n, k, acc0, tries;
  logic [7:0]  rb;

  initial begin
    bif.bus_sel = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'd0, rs_wr_en}, 32'd0);
    check("rst_rd_en", {31'd0, rs_rd_en}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ready", {31'd0, bif.bus_ready}, 32'd0);
    check("rst_rdata", bif.bus_rdata, 32'd0);
    check("rst_wr_data", {24'd0, rs_wr_data}, 32'd0);
    rst_n = 1'b1;
    rd(4'h4, v); check("rst_status", v, 32'h04);
    rd(4'h8, v); check("rst_ctrl", v, 32'h3);
    rd(4'hC, v); check("reg_c_read", v, 32'h0);

    // TX pacing
    tx_seen.delete(); tx_cyc.delete();
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    wr(4'h0, {24'd0, b[0]}); acc0 = last_acc;
    wr(4'h0, {$urandom, b[1]});
    wr(4'h0, {24'd0, b[2]});
    wait_tx(3, 60);
    check("tx3_count", tx_seen.size(), 32'd3);
    if (tx_seen.size() == 3) begin
      for (int i = 0; i < 3; i++) check("tx3_data", {24'd0, tx_seen[i]}, {24'd0, b[i]});
      check("tx3_first_lat", tx_cyc[0] - acc0, 32'd1);
      check("tx3_space1", tx_cyc[1] - tx_cyc[0], GAP + 1);
      check("tx3_space2", tx_cyc[2] - tx_cyc[1], GAP + 1);
    end
    check("irq_no_ie", {31'd0, irq}, 32'd0);

    // TX overflow with TX disabled
    wr(4'h8, 32'h2);
    repeat (8) @(negedge clk);
    tx_seen.delete(); tx_cyc.delete(); tx_model.delete(); ovf = 1'b0;
    n = $urandom_range(9, 12);
    for (int i = 0; i < n; i++) begin
      rb = 8'($urandom);
      wr(4'h0, {24'd0, rb});
      if (tx_model.size() < TXD) tx_model.push_back(rb); else ovf = 1'b1;
    end
    rd(4'h4, v); check("ovf_status", v, status_of(0, tx_model.size(), ovf));
    wr(4'h4, $urandom | 32'h10);
    rd(4'h4, v); check("ovf_cleared", v, status_of(0, tx_model.size(), 1'b0));
    check("tx_disabled_idle", tx_seen.size(), 32'd0);
    rd(4'h8, v); check("ctrl_readback", v, 32'h2);
    wr(4'h8, 32'h3);
    wait_tx(TXD, TXD * (GAP + 1) + 20);
    repeat (20) @(negedge clk);
    check("ovf_drain_count", tx_seen.size(), tx_model.size());
    for (int i = 0; i < tx_model.size() && i < tx_seen.size(); i++)
      check("ovf_drain_data", {24'd0, tx_seen[i]}, {24'd0, tx_model[i]});

    // Single RX byte and poll period
    rd_cyc.delete();
    rb = 8'($urandom);
    src_q.push_back(rb);
    for (int i = 0; i < 4 * (PI + 2) && rd_cyc.size() < 3; i++) @(negedge clk);
    check("poll_count", rd_cyc.size() >= 3, 32'd1);
    if (rd_cyc.size() >= 3) begin
      check("poll_period1", rd_cyc[1] - rd_cyc[0], PI + 2);
      check("poll_period2", rd_cyc[2] - rd_cyc[1], PI + 2);
    end
    rd(4'h4, v); check("rx1_status", v, status_of(1, 0, 1'b0));
    rd(4'h0, v); check("rx1_data", v, {24'd0, rb});
    rd(4'h0, v); check("rx1_empty_read", v, 32'd0);

    // RX fill to full, stall, resume
    rx_exp.delete();
    k = RXD + 2;
    for (int i = 0; i < k; i++) begin
      rb = 8'($urandom);
      src_q.push_back(rb); rx_exp.push_back(rb);
    end
    repeat ((PI + 2) * (RXD + 2)) @(negedge clk);
    rd(4'h4, v); check("rx_full_status", v, status_of(RXD, 0, 1'b0));
    rd_cyc.delete();
    repeat (3 * (PI + 2)) @(negedge clk);
    check("rx_full_no_poll", rd_cyc.size(), 32'd0);
    rd(4'h0, v); check("rx_full_data0", v, {24'd0, rx_exp[0]});
    acc0 = last_acc;
    for (int i = 0; i < PI + 3 && rd_cyc.size() == 0; i++) @(negedge clk);
    check("rx_resume", (rd_cyc.size() > 0) && (rd_cyc[0] - acc0 <= PI + 1), 32'd1);
    for (int i = 1; i < k; i++) begin
      tries = 0;
      v = 32'd0;
      while (tries < 40 && v[0] !== 1'b1) begin
        rd(4'h4, v);
        tries++;
      end
      rd(4'h0, v); check("rx_full_data", v, {24'd0, rx_exp[i]});
    end
    rd(4'h0, v); check("rx_drained", v, 32'd0);
    check("src_consumed", src_q.size(), 32'd0);

    // Interrupts
    wr(4'h8, 32'hF);
    check("irq_tx_empty", {31'd0, irq}, 32'd1);
    tx_seen.delete();
    wr(4'h0, {24'd0, 8'($urandom)});
    check("irq_tx_pending", {31'd0, irq}, 32'd0);
    wait_tx(1, 10);
    @(negedge clk);
    check("irq_tx_sent", {31'd0, irq}, 32'd1);
    wr(4'h8, 32'hA);
    check("irq_rx_idle", {31'd0, irq}, 32'd0);
    rb = 8'($urandom);
    src_q.push_back(rb);
    for (int i = 0; i < 3 * (PI + 2) && irq !== 1'b1; i++) @(negedge clk);
    check("irq_rx_ne", {31'd0, irq}, 32'd1);
    rd(4'h0, v); check("irq_rx_data", v, {24'd0, rb});
    check("irq_rx_cleared", {31'd0, irq}, 32'd0);

    // Reset in the middle of a TX gap with bytes queued
    wr(4'h8, 32'h2);
    for (int i = 0; i < 4; i++) wr(4'h0, {24'd0, 8'($urandom)});
    tx_seen.delete();
    wr(4'h8, 32'h3);
    wait_tx(1, 10);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_wr_en", {31'd0, rs_wr_en}, 32'd0);
    check("rstmid_wr_data", {24'd0, rs_wr_data}, 32'd0);
    check("rstmid_rd_en", {31'd0, rs_rd_en}, 32'd0);
    check("rstmid_ready", {31'd0, bif.bus_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(4'h4, v); check("rstmid_status", v, 32'h04);
    tx_seen.delete();
    repeat (40) @(negedge clk);
    check("rstmid_no_tx", tx_seen.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
